// File: rtl/mmio_fifo_pkg.sv
// Shared constants for the MMIO FIFO endpoint: default addresses, status/control
// bit positions and CCI-P widths.
package mmio_fifo_pkg;

  localparam logic [15:0] DEF_DATA_ADDR = 16'h0030;
  localparam logic [15:0] DEF_STAT_ADDR = 16'h0032;
  localparam logic [15:0] DEF_CTRL_ADDR = 16'h0034;

  localparam int STAT_EMPTY   = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_OVF     = 2;
  localparam int STAT_UDF     = 3;
  localparam int STAT_CNT_LSB = 8;

  localparam int CTRL_FLUSH = 0;
  localparam int CTRL_CLR   = 1;

  localparam int TID_W  = 9;
  localparam int DATA_W = 64;

endpackage

// File: rtl/mmio_fifo_ram.sv
// FIFO storage: synchronous write, asynchronous read so the head word is
// available in the same cycle the pop is decoded.
module mmio_fifo_ram
  import mmio_fifo_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mmio_fifo_port.sv
// MMIO-mapped FIFO endpoint: writes to DATA_ADDR push, reads pop; STAT_ADDR and
// CTRL_ADDR expose occupancy/sticky flags and flush/clear. Responses are 1-cycle registered.
module mmio_fifo_port
  import mmio_fifo_pkg::*;
#(
  parameter int          DEPTH     = 8,
  parameter logic [15:0] DATA_ADDR = DEF_DATA_ADDR,
  parameter logic [15:0] STAT_ADDR = DEF_STAT_ADDR,
  parameter logic [15:0] CTRL_ADDR = DEF_CTRL_ADDR
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_valid,
  input  logic [15:0]                wr_addr,
  input  logic [63:0]                wr_data,
  input  logic                       rd_valid,
  input  logic [15:0]                rd_addr,
  input  logic [8:0]                 rd_tid,
  output logic                       resp_valid,
  output logic [8:0]                 resp_tid,
  output logic [63:0]                resp_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              ovf_flag, udf_flag;
  logic [DATA_W-1:0] head_word;

  logic push, pop, stat_rd, ctrl_wr;
  logic empty, full, push_ok, pop_ok;
  logic ovf_set, udf_set, flush, clr;
  logic [CNT_W-1:0] count_nxt;

  function automatic logic [DATA_W-1:0] status_word(
    input logic [CNT_W-1:0] cnt,
    input logic             e,
    input logic             f,
    input logic             o,
    input logic             u
  );
    logic [DATA_W-1:0] s;
    s                       = '0;
    s[STAT_EMPTY]           = e;
    s[STAT_FULL]            = f;
    s[STAT_OVF]             = o;
    s[STAT_UDF]             = u;
    s[STAT_CNT_LSB +: CNT_W] = cnt;
    return s;
  endfunction

  assign push    = wr_valid && (wr_addr == DATA_ADDR);
  assign ctrl_wr = wr_valid && (wr_addr == CTRL_ADDR);
  assign pop     = rd_valid && (rd_addr == DATA_ADDR);
  assign stat_rd = rd_valid && (rd_addr == STAT_ADDR);

  assign empty = (count == '0);
  assign full  = (count == CNT_FULL);

  // A push into a full FIFO still lands when a pop frees the head slot this cycle.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  assign ovf_set = push && full && !pop;
  assign udf_set = pop && empty;
  assign flush   = ctrl_wr && wr_data[CTRL_FLUSH];
  assign clr     = ctrl_wr && wr_data[CTRL_CLR];

  always_comb begin
    count_nxt = count;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  mmio_fifo_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (push_ok && !flush),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (head_word)
  );

  // Pointer / occupancy / sticky flag state
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ovf_flag <= 1'b0;
      udf_flag <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count_nxt;
      end
      // Set has priority over a same-cycle clear.
      if (ovf_set)  ovf_flag <= 1'b1;
      else if (clr) ovf_flag <= 1'b0;
      if (udf_set)  udf_flag <= 1'b1;
      else if (clr) udf_flag <= 1'b0;
    end
  end

  // Response stage: registered one cycle after the owned read
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_tid   <= '0;
      resp_data  <= '0;
    end else begin
      resp_valid <= pop || stat_rd;
      if (pop) begin
        resp_tid  <= rd_tid;
        resp_data <= empty ? '0 : head_word;
      end else if (stat_rd) begin
        resp_tid  <= rd_tid;
        resp_data <= status_word(count, empty, full, ovf_flag, udf_flag);
      end
    end
  end

endmodule

// File: tb/tb_mmio_fifo_port.sv
// Directed self-checking bench for mmio_fifo_port (DEPTH=8, default addresses).
module tb_mmio_fifo_port;

  localparam logic [15:0] DA = 16'h0030;
  localparam logic [15:0] SA = 16'h0032;
  localparam logic [15:0] CA = 16'h0034;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic [15:0] wr_addr;
  logic [63:0] wr_data;
  logic        rd_valid;
  logic [15:0] rd_addr;
  logic [8:0]  rd_tid;
  logic        resp_valid;
  logic [8:0]  resp_tid;
  logic [63:0] resp_data;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;

  mmio_fifo_port #(.DEPTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_valid   (rd_valid),
    .rd_addr    (rd_addr),
    .rd_tid     (rd_tid),
    .resp_valid (resp_valid),
    .resp_tid   (resp_tid),
    .resp_data  (resp_data),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] d);
    wr_valid = 1'b1; wr_addr = DA; wr_data = d;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic ctrl(input logic [63:0] d);
    wr_valid = 1'b1; wr_addr = CA; wr_data = d;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [8:0] t);
    rd_valid = 1'b1; rd_addr = a; rd_tid = t;
    step();
    rd_valid = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [8:0] t, input logic [63:0] exp_d);
    rd(DA, t);
    chk({tag, "_vld"}, 64'(resp_valid), 64'd1);
    chk({tag, "_tid"}, 64'(resp_tid), 64'(t));
    chk({tag, "_data"}, resp_data, exp_d);
  endtask

  task automatic stat_chk(input string tag, input logic [63:0] exp_s);
    rd(SA, 9'h1F);
    chk({tag, "_vld"}, 64'(resp_valid), 64'd1);
    chk({tag, "_word"}, resp_data, exp_s);
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    rd_valid = 1'b0; rd_addr = '0; rd_tid = '0;
    step(); step();
    chk("rst_vld", 64'(resp_valid), 64'd0);
    chk("rst_tid", 64'(resp_tid), 64'd0);
    chk("rst_data", resp_data, 64'd0);
    chk("rst_cnt", 64'(count), 64'd0);
    rst = 1'b0;
    step();

    // Basic push/pop with TID echo
    push(64'hA); push(64'hB); push(64'hC);
    chk("cnt3", 64'(count), 64'd3);
    pop_chk("popA", 9'd1, 64'hA);
    step();
    chk("idle_vld", 64'(resp_valid), 64'd0);
    chk("hold_data", resp_data, 64'hA);
    pop_chk("popB", 9'd2, 64'hB);
    pop_chk("popC", 9'd3, 64'hC);
    chk("cnt0", 64'(count), 64'd0);

    // Overflow: 9 pushes into 8 entries
    for (int i = 1; i <= 9; i++) push(64'(i));
    chk("cnt_full", 64'(count), 64'd8);
    stat_chk("stat_ovf", 64'h806);
    for (int i = 1; i <= 8; i++) pop_chk("pop_ovf", 9'(i), 64'(i));
    chk("cnt_drain", 64'(count), 64'd0);

    // Underflow, then clear flags
    pop_chk("pop_empty", 9'd7, 64'd0);
    stat_chk("stat_udf", 64'hD);
    ctrl(64'h2);
    stat_chk("stat_clr", 64'h1);

    // Simultaneous push and pop while full
    for (int i = 0; i < 8; i++) push(64'h10 + 64'(i));
    wr_valid = 1'b1; wr_addr = DA; wr_data = 64'h55;
    rd_valid = 1'b1; rd_addr = DA; rd_tid = 9'd9;
    step();
    wr_valid = 1'b0; rd_valid = 1'b0;
    chk("pp_full_data", resp_data, 64'h10);
    chk("pp_full_cnt", 64'(count), 64'd8);
    stat_chk("stat_pp_full", 64'h802);
    for (int i = 1; i < 8; i++) pop_chk("pop_pp", 9'(i), 64'h10 + 64'(i));
    pop_chk("pop_55", 9'd8, 64'h55);

    // Simultaneous push and pop while empty
    wr_valid = 1'b1; wr_addr = DA; wr_data = 64'h77;
    rd_valid = 1'b1; rd_addr = DA; rd_tid = 9'd4;
    step();
    wr_valid = 1'b0; rd_valid = 1'b0;
    chk("pp_empty_vld", 64'(resp_valid), 64'd1);
    chk("pp_empty_data", resp_data, 64'd0);
    chk("pp_empty_cnt", 64'(count), 64'd1);
    stat_chk("stat_pp_empty", 64'h108);
    ctrl(64'h3);
    stat_chk("stat_flush_clr", 64'h1);

    // Flush with data present, then unmapped read
    for (int i = 0; i < 4; i++) push(64'h20 + 64'(i));
    chk("cnt4", 64'(count), 64'd4);
    ctrl(64'h1);
    stat_chk("stat_flush", 64'h1);
    rd(16'h0040, 9'd3);
    chk("unmapped_vld", 64'(resp_valid), 64'd0);

    // Reset asserted during a pop
    push(64'h99);
    rst = 1'b1;
    rd_valid = 1'b1; rd_addr = DA; rd_tid = 9'd6;
    step();
    rst = 1'b0; rd_valid = 1'b0;
    chk("rstpop_vld", 64'(resp_valid), 64'd0);
    chk("rstpop_tid", 64'(resp_tid), 64'd0);
    chk("rstpop_data", resp_data, 64'd0);
    chk("rstpop_cnt", 64'(count), 64'd0);
    stat_chk("stat_after_rst", 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_fifo_port.md
# mmio_fifo_port

MMIO-mapped FIFO endpoint that sits between the CCI-P MMIO request decode in the AFU and the Tx c2 read-response path. Host MMIO writes to a data address push 64-bit words; MMIO reads of that address pop them. Reads of a status address return occupancy and sticky error flags; a control address provides flush and flag-clear. Each owned read produces a registered response (data plus the echoed TID) that the AFU forwards onto Tx c2.

## Interface
Parameters:
- DEPTH, 8: FIFO entries; power of two, 2..128.
- DATA_ADDR, 16'h0030: MMIO word address; write = push, read = pop.
- STAT_ADDR, 16'h0032: MMIO word address; read-only status.
- CTRL_ADDR, 16'h0034: MMIO word address; write-only control.

Ports:
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- wr_valid  in  1  MMIO write strobe (rx.c0.mmioWrValid).
- wr_addr  in  16  MMIO write word address.
- wr_data  in  64  MMIO write data.
- rd_valid  in  1  MMIO read strobe (rx.c0.mmioRdValid).
- rd_addr  in  16  MMIO read word address.
- rd_tid  in  9  read request TID.
- resp_valid  out  1  read response valid; drives tx.c2.mmioRdValid when set.
- resp_tid  out  9  echoed TID.
- resp_data  out  64  response payload.
- count  out  $clog2(DEPTH)+1  current occupancy, for debug.

## Operation
- Push: wr_valid && wr_addr==DATA_ADDR.
  - If not full: the word is stored at the write pointer, the pointer increments modulo DEPTH, and count increments.
  - If full: the word is dropped, count is unchanged, and the sticky overflow flag is set.
- Pop: rd_valid && rd_addr==DATA_ADDR.
  - If not empty: resp_data is the head word, the read pointer increments modulo DEPTH, and count decrements.
  - If empty: resp_data is 0 and the sticky underflow flag is set.
- Status read: rd_valid && rd_addr==STAT_ADDR.
  - resp_data[0]=empty, [1]=full, [2]=overflow, [3]=underflow, [15:8]=count (zero-extended); all other bits 0.
  - The value is sampled before any same-cycle update.
- Control write: wr_valid && wr_addr==CTRL_ADDR.
  - bit0=flush: both pointers and count go to 0; stored data is not cleared.
  - bit1=clear sticky flags.
  - Both bits may be set together.
- Reads of any other address produce no response (resp_valid stays 0). Writes to any other address are ignored.
- Simultaneous push and pop in the same cycle are both processed:
  - When full, both succeed, count is unchanged and no overflow is flagged.
  - When empty, the pop returns 0 and flags underflow, and the push is stored (count becomes 1).
- Flush coinciding with a pop: the response carries the pre-flush head word and the FIFO ends empty.
- Flag set and clear in the same cycle: set wins.
- Reset: pointers, count, flags, resp_valid, resp_tid and resp_data are all 0. Storage contents are don't-care.

## Timing
- Read latency is exactly 1 cycle. resp_valid, resp_tid and resp_data are registered and are valid in the cycle after rd_valid.
- resp_valid is a single-cycle pulse per owned read. Back-to-back reads give back-to-back responses, with no stall and no backpressure.
- A push is visible to a pop or status read issued in the next cycle, not in the same cycle.
- count and flags update at the clock edge following the request.
- resp_data holds its last value while resp_valid=0.
- rst asserted mid-stream clears all state at the next edge. A response pending for that edge is suppressed (resp_valid=0).

## Structure
- Package mmio_fifo_pkg holds:
  - default address constants;
  - status bit indices (STAT_EMPTY=0, STAT_FULL=1, STAT_OVF=2, STAT_UDF=3, STAT_CNT_LSB=8);
  - control bit indices (CTRL_FLUSH=0, CTRL_CLR=1);
  - TID width 9.
- Sub-module mmio_fifo_ram: DEPTH x 64 storage with a synchronous write and an asynchronous read at the read pointer. Pointer, count and flag logic stays in the top module.

## Test plan
- Push 0xA, 0xB, 0xC to DATA_ADDR, then pop three times with tids 1, 2, 3 -> responses 0xA/tid1, 0xB/tid2, 0xC/tid3, each 1 cycle after its request; count returns to 0.
- Push DEPTH+1 words (1..9 with DEPTH=8) -> status read gives full=1, overflow=1, count=8; the subsequent 8 pops return 1..8.
- Pop when empty -> resp_data=0; status then shows empty=1, underflow=1. Write CTRL=0x2 -> status read shows flags cleared.
- With FIFO full, issue push 0x55 and pop in the same cycle -> pop returns the oldest word, count stays 8, overflow stays 0, and 0x55 is popped last.
- After pushing 4 words, write CTRL=0x1 -> status shows empty=1, count=0. Read of address 0x0040 -> no resp_valid.
- Assert rst for one cycle during a pop -> no response in the following cycle; all outputs are 0 and the status read shows empty=1.
